// File: rtl/cmp_pkg.sv
// Shared types for the serial magnitude comparator: FSM states, one-hot result
// encoding and the digit-index width helper.
package cmp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    // One-hot result, bit order {gt, eq, lt}.
    typedef logic [2:0] res_t;

    localparam res_t RES_NONE = 3'b000;
    localparam res_t RES_GT   = 3'b100;
    localparam res_t RES_EQ   = 3'b010;
    localparam res_t RES_LT   = 3'b001;

    function automatic int unsigned idx_width(input int unsigned ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/digit_cmp.sv
// Combinational unsigned compare of one DIGIT-bit slice of each operand.
module digit_cmp #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    output logic             gt_o,
    output logic             eq_o,
    output logic             lt_o
);

    assign gt_o = (a_i > b_i);
    assign eq_o = (a_i == b_i);
    assign lt_o = (a_i < b_i);

endmodule

// File: rtl/comparator_serial_sign.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle, signed or
// unsigned, with early exit on the first differing digit.
module comparator_serial_sign
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             is_signed_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             gt_o,
    output logic             eq_o,
    output logic             lt_o
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned IW   = idx_width(NDIG);
    localparam logic [IW-1:0] IdxTop = IW'(NDIG - 1);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("comparator_serial_sign: DIGIT must divide WIDTH");
    end

    state_e          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]   idx_q, idx_d;
    res_t            res_q, res_d;
    logic            valid_q, valid_d;

    logic [DIGIT-1:0] a_dig, b_dig;
    logic             dig_gt, dig_eq, dig_lt;

    assign a_dig = a_q[idx_q*DIGIT +: DIGIT];
    assign b_dig = b_q[idx_q*DIGIT +: DIGIT];

    digit_cmp #(
        .DIGIT (DIGIT)
    ) u_digit_cmp (
        .a_i  (a_dig),
        .b_i  (b_dig),
        .gt_o (dig_gt),
        .eq_o (dig_eq),
        .lt_o (dig_lt)
    );

    // The signedness only matters at accept time: once the sign bits match, an
    // unsigned scan of the two's complement words orders them correctly.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        res_d   = res_q;
        valid_d = valid_q;

        case (state_q)
            StIdle: begin
                if (start_valid_i) begin
                    a_d   = a_i;
                    b_d   = b_i;
                    idx_d = IdxTop;
                    if (is_signed_i && (a_i[WIDTH-1] != b_i[WIDTH-1])) begin
                        state_d = StDone;
                        valid_d = 1'b1;
                        res_d   = a_i[WIDTH-1] ? RES_LT : RES_GT;
                    end else begin
                        state_d = StScan;
                    end
                end
            end

            StScan: begin
                if (!dig_eq) begin
                    state_d = StDone;
                    valid_d = 1'b1;
                    res_d   = dig_gt ? RES_GT : RES_LT;
                end else if (idx_q == '0) begin
                    state_d = StDone;
                    valid_d = 1'b1;
                    res_d   = RES_EQ;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end

            StDone: begin
                if (res_ready_i) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    res_d   = RES_NONE;
                end
            end

            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
                res_d   = RES_NONE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= IdxTop;
            res_q   <= RES_NONE;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    // dig_lt is implied by !dig_gt && !dig_eq; keep it observed for clarity.
    logic unused_dig_lt;
    assign unused_dig_lt = dig_lt;

    assign start_ready_o = (state_q == StIdle);
    assign res_valid_o   = valid_q;
    assign gt_o          = res_q[2];
    assign eq_o          = res_q[1];
    assign lt_o          = res_q[0];

endmodule

// File: tb/tb_comparator_serial_sign.sv
// Randomised self-checking bench: DIGIT=4 and DIGIT=32 instances checked against
// an arithmetic reference model of result and latency.
module tb_comparator_serial_sign;
    import cmp_pkg::*;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [W-1:0]  a, b;
    logic          is_signed;
    logic [1:0]    sv, rr, srdy, rv, gt, eq, lt;

    int nvec = 0;
    int nerr = 0;

    comparator_serial_sign #(.WIDTH(W), .DIGIT(4)) u_dig4 (
        .clk_i(clk), .reset_i(reset), .start_valid_i(sv[0]), .start_ready_o(srdy[0]),
        .a_i(a), .b_i(b), .is_signed_i(is_signed), .res_valid_o(rv[0]),
        .res_ready_i(rr[0]), .gt_o(gt[0]), .eq_o(eq[0]), .lt_o(lt[0])
    );

    comparator_serial_sign #(.WIDTH(W), .DIGIT(32)) u_dig32 (
        .clk_i(clk), .reset_i(reset), .start_valid_i(sv[1]), .start_ready_o(srdy[1]),
        .a_i(a), .b_i(b), .is_signed_i(is_signed), .res_valid_o(rv[1]),
        .res_ready_i(rr[1]), .gt_o(gt[1]), .eq_o(eq[1]), .lt_o(lt[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] ref_rel(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
        logic xgt, xlt;
        xgt = s ? ($signed(x) > $signed(y)) : (x > y);
        xlt = s ? ($signed(x) < $signed(y)) : (x < y);
        return {xgt, !xgt && !xlt, xlt};
    endfunction

    // Latency: 1 for a signed sign mismatch, else digits examined + 1.
    function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input int dig);
        int nd;
        nd = W / dig;
        if (s && (x[W-1] != y[W-1])) return 1;
        for (int k = 1; k <= nd; k++) begin
            if ((x >> (W - k * dig)) != (y >> (W - k * dig))) return k + 1;
        end
        return nd + 1;
    endfunction

    function automatic logic [2:0] outs(input int d);
        return {gt[d], eq[d], lt[d]};
    endfunction

    task automatic txn(input int d, input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic si, input int e_lat, input logic [2:0] e_rel,
                       input int hold, input bit poke);
        int lat;
        string p;
        p = $sformatf("dut%0d %h/%h s%0d", d, ai, bi, si);
        @(negedge clk);
        check({p, " ready"}, 32'(srdy[d]), 32'd1);
        a = ai; b = bi; is_signed = si; sv[d] = 1'b1;
        @(posedge clk); #1;
        sv[d] = 1'b0;
        a = $urandom; b = $urandom; is_signed = 1'($urandom);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            if (rv[d]) begin
                lat = c;
                break;
            end
            if (outs(d) != 3'b000) check({p, " idle_outs"}, 32'(outs(d)), 32'd0);
            @(posedge clk); #1;
        end
        check({p, " latency"}, lat, e_lat);
        check({p, " result"}, 32'(outs(d)), 32'(e_rel));
        if (lat == 0) return;
        for (int h = 0; h < hold; h++) begin
            if (poke && h == 1) begin
                sv[d] = 1'b1;
                a = ~ai;
                b = bi + 1;
            end
            @(posedge clk); #1;
            sv[d] = 1'b0;
            check({p, " hold"}, {28'd0, srdy[d], outs(d)}, {28'd0, 1'b0, e_rel});
        end
        rr[d] = 1'b1;
        @(posedge clk); #1;
        rr[d] = 1'b0;
        check({p, " release"}, {29'd0, rv[d], srdy[d], |outs(d)}, {29'd0, 3'b010});
        if (poke) begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 12; c++) begin
                @(posedge clk); #1;
                if (rv[d] || !srdy[d]) seen = 1'b1;
            end
            check({p, " poke_ignored"}, 32'(seen), 32'd0);
        end
    endtask

    task automatic rand_txn(input int d);
        logic [W-1:0] ai, bi;
        logic si;
        ai = $urandom;
        case ($urandom % 4)
            0: bi = ai;
            1: bi = ai ^ (32'd1 << ($urandom % 32));
            2: bi = $urandom;
            default: bi = {~ai[W-1], ai[W-2:0]};
        endcase
        si = 1'($urandom);
        txn(d, ai, bi, si, ref_lat(ai, bi, si, (d == 0) ? 4 : 32), ref_rel(ai, bi, si),
            int'($urandom % 3), 1'b0);
    endtask

    initial begin
        bit seen;
        reset = 1'b1; sv = '0; rr = '0; a = '0; b = '0; is_signed = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d reset_state", d), {28'd0, srdy[d], rv[d], outs(d)},
                  {28'd0, 1'b1, 1'b0, 3'b000});
        end

        // Directed cases, DIGIT=4.
        txn(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1, 3'b001, 0, 1'b0);
        txn(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 2, 3'b100, 0, 1'b0);
        txn(0, 32'h1234_5678, 32'h1234_5678, 1'b1, 9, 3'b010, 0, 1'b0);
        txn(0, 32'h0000_0020, 32'h0000_0011, 1'b1, 8, 3'b100, 0, 1'b0);
        txn(0, 32'h0000_0011, 32'h0000_0020, 1'b1, 8, 3'b001, 0, 1'b0);
        txn(0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 2, 3'b100, 0, 1'b0);
        // Backpressure with an ignored start pulse.
        txn(0, 32'hCAFE_0001, 32'hCAFE_0001, 1'b0, 9, 3'b010, 5, 1'b1);
        // Single-digit instance.
        txn(1, 32'h1234_5678, 32'h1234_5678, 1'b1, 2, 3'b010, 0, 1'b0);
        txn(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1, 3'b001, 0, 1'b0);
        txn(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 2, 3'b100, 2, 1'b1);

        // Reset in the third SCAN cycle discards the request.
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h1234_5678; is_signed = 1'b1; sv[0] = 1'b1;
        @(posedge clk); #1;
        sv[0] = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset_mid_scan outs", {28'd0, srdy[0], rv[0], outs(0)},
              {28'd0, 1'b1, 1'b0, 3'b000});
        check("reset_mid_scan state", 32'(u_dig4.state_q), 32'(StIdle));
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (rv[0]) seen = 1'b1;
        end
        check("reset_mid_scan no_result", 32'(seen), 32'd0);

        for (int i = 0; i < 40; i++) begin
            rand_txn(0);
            rand_txn(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/comparator_serial_sign.md
# comparator_serial_sign

Parametrised, multi-cycle magnitude comparator: the successor to the fixed 32-bit signed comparator in the MIPS32 datapath. It compares two WIDTH-bit operands MSB-first, DIGIT bits per cycle, in either signed (two's complement) or unsigned mode. It terminates early on the first differing digit and returns one-hot gt/eq/lt over a valid/ready handshake. It serves area-constrained paths (multi-cycle SLT/SLTU, branch-compare offload) where a full-width single-cycle comparator is not justified.

## Interface
- WIDTH, 32, operand width in bits.
- DIGIT, 4, bits compared per cycle; must divide WIDTH; DIGIT == WIDTH gives a single-cycle scan.
- NDIG, WIDTH/DIGIT, derived localparam; number of digits.
- clk  in  1  the single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; returns the block to IDLE.
- start_valid  in  1  request present.
- start_ready  out  1  block can accept a request; high only in IDLE.
- a, b  in  WIDTH  operands; sampled only on the start handshake.
- is_signed  in  1  1 = two's complement compare, 0 = unsigned; sampled with the operands.
- res_valid  out  1  result present.
- res_ready  in  1  consumer accepts the result.
- gt, eq, lt  out  1 each  registered result, meaning a>b, a==b, a<b; exactly one is high while res_valid=1, all are 0 otherwise.

## Operation
- FSM states: IDLE, SCAN, DONE.
- Reset values: state=IDLE, res_valid=0, gt=eq=lt=0, digit index=NDIG-1. As a result, start_ready=1 in the first cycle after reset is released.
- IDLE, on start_valid & start_ready:
  - Latch a, b and is_signed into internal registers.
  - Set the digit index to NDIG-1.
  - If is_signed=1 and a[WIDTH-1] != b[WIDTH-1]: go directly to DONE with lt=a[WIDTH-1] and gt=~a[WIDTH-1].
  - Otherwise go to SCAN.
- SCAN, each cycle, compares digit idx of the latched operands (bits idx*DIGIT+DIGIT-1 down to idx*DIGIT) as unsigned values:
  - If the digits differ: go to DONE with gt or lt set from the digit compare.
  - Else if idx == 0: go to DONE with eq=1.
  - Else: decrement idx.
- Signed correctness: SCAN is entered in signed mode only when the sign bits match, and in that case an unsigned compare of the full two's complement words gives the correct signed result. No other sign handling is needed in SCAN.
- DONE: res_valid=1 and gt/eq/lt are held stable until res_ready=1. On that handshake, clear res_valid and gt/eq/lt and return to IDLE.
- start_valid while the block is not in IDLE is ignored and is not queued. Operand changes after the start handshake have no effect.
- Reset in any state, including mid-SCAN or in DONE with res_valid=1: the block is in IDLE with reset values after the next edge, and any in-flight result is discarded without being presented.

## Timing
- Latency is counted from the accepting edge (start handshake) to the first cycle with res_valid=1:
  - Signed compare with differing sign bits: 1 cycle.
  - Otherwise: k+1 cycles, where k (1..NDIG) is the number of digits examined. Worst case, for equality, is NDIG+1 (9 cycles for 32/4).
- There is no overlap between requests. In the cycle where the result handshake occurs, start_ready=0. The earliest next accept is the following cycle, so minimum spacing between accepts is latency+1 cycles.
- gt/eq/lt and res_valid are registered, with no combinational path from inputs to outputs. start_ready is a decode of the state register only.

## Structure
- Shared package cmp_pkg holds:
  - the state enum (IDLE, SCAN, DONE);
  - a 3-bit one-hot result encoding {gt,eq,lt} with named constants RES_GT, RES_EQ, RES_LT and RES_NONE=0;
  - a width function for the digit index, $clog2(NDIG) with a minimum of 1.
- One sub-module, digit_cmp: a combinational DIGIT-bit unsigned compare with outputs gt, eq, lt. It is instantiated once, and its operands are selected by the index mux.
- An elaboration-time check fails if WIDTH % DIGIT != 0.

## Test plan
- Signed, a=0xFFFFFFFF (-1), b=0x00000001: lt=1, res_valid 1 cycle after the accept, no SCAN cycles.
- Unsigned, same operands: gt=1 after 2 cycles (top digit F vs 0).
- Signed, a=b=0x12345678: eq=1 after 9 cycles; gt=lt=0 throughout.
- Signed, a=0x00000020, b=0x00000011: gt=1 after 8 cycles (operands differ at digit 1). Swapping the operands gives lt=1 after 8 cycles.
- Backpressure, eq result held with res_ready=0 for 5 cycles: gt/eq/lt stay stable, start_ready=0, and a start_valid pulse in that window is ignored. After res_ready=1, the block is back in IDLE on the next cycle.
- Reset pulse in the 3rd SCAN cycle: on the next cycle state=IDLE, res_valid=0, gt=eq=lt=0 and start_ready=1, and no result is ever presented for that request. Also run DIGIT=32: every compare completes in at most 2 cycles.
